id_stage_pipe: RTL
==================

Name: id_stage_pipe

Overview:
Parametrised successor to the ID stage. It decodes RV32I/M instructions and holds the register file with write-through bypass. It adds a registered ID/EX output with a valid/ready handshake, a load-use/WAW scoreboard that stalls issue, a flush input, and RV32E (16-register) support. It sits between the IF/ID register and the EX stage.

Parameters:
XLEN, 32, data width of register file, PC and immediate (sign-extended to XLEN).
NREGS, 32, architectural register count; only 32 or 16 are legal (16 = RV32E).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF/ID holds an instruction
in_ready  out  1  ID accepts in_instr/in_pc this cycle
in_instr  in  32  instruction word
in_pc  in  XLEN  instruction PC
flush  in  1  kill the ID/EX register and drop the incoming instruction
wb_en  in  1  writeback strobe
wb_rd  in  5  writeback destination
wb_data  in  XLEN  writeback value
ex_valid  out  1  ID/EX register holds a valid instruction
ex_ready  in  1  EX consumes the ID/EX register
ex_pc  out  XLEN  registered PC
ex_rs1_val, ex_rs2_val  out  XLEN each  registered operands
ex_imm  out  XLEN  registered immediate
ex_rd, ex_rs1, ex_rs2  out  5 each  registered register indices
ex_funct3  out  3  registered funct3
ex_aluop  out  2  00 add/I, 01 branch, 10 R-type, 11 AUIPC
ex_ctrl  out  11  {RegWrite, ALUSrc, MemRead, MemWrite, Branch, Jump, Jump_r, memtoreg, AUIPC, LUI, MulDiv}, MSB first
ex_illegal  out  1  unknown opcode, or register index >= NREGS

Behaviour:
- Clock and reset: one clock, clk; rst is synchronous, active-high.
- Reset values:
  - ex_valid=0 and all ex_* outputs 0.
  - Scoreboard cleared.
  - Register file reset to 0 (every register, via a synchronous loop).
  - in_ready=0 during the rst cycle.
- Decode: combinational from in_instr.
  - Field, immediate and control encodings for R, I, load, S, B, U, JAL, JALR, LUI, AUIPC are the same as the current ID stage.
  - Unused fields decode to 0.
  - Immediates are sign-extended to XLEN.
- Register read: x0 always reads 0.
  - Write-through bypass: when wb_en && wb_rd==rs && rs!=0, the operand is wb_data.
- Register write: on the clk edge when wb_en && wb_rd!=0 && wb_rd<NREGS.
- Scoreboard: busy[NREGS-1:1].
  - A load issued with rd!=0 sets busy[rd].
  - wb_en && wb_rd==r clears busy[r].
  - If set and clear hit the same register in the same cycle, set wins.
- hazard = (uses_rs1 && busy[rs1]) || (uses_rs2 && busy[rs2]) || (RegWrite && rd!=0 && busy[rd]).
  - A busy bit being cleared this cycle counts as not busy (bypass covers the data).
  - uses_rs1/uses_rs2 follow the instruction format.
- in_ready = !rst && !flush && !hazard && (!ex_valid || ex_ready).
- Issue happens when in_valid && in_ready. On the next edge:
  - the ID/EX register loads the decode results;
  - ex_valid=1;
  - the scoreboard updates.
  - Latency is 1 cycle.
- Hold: ex_valid && !ex_ready keeps every ex_* output stable.
- Drain: ex_ready with no issue gives ex_valid=0 next cycle.
- flush: ex_valid=0 next cycle and the incoming instruction is not accepted.
  - Scoreboard bits of loads already issued stay set; their writeback still clears them.
  - A load killed by flush while still in ID/EX also clears its busy bit in the same edge.
- Illegal instruction: it still issues with ex_illegal=1 and all ex_ctrl bits 0.
  - It never sets the scoreboard.
  - It never writes the register file.
- Reset mid-stall: rst overrides flush, hazard and handshake. The scoreboard is cleared, so no stale stalls remain.
- NREGS=16:
  - rs/rd >= 16 flags illegal;
  - register index bits [4] are ignored for array indexing only after the legality check.

Optional Feature:
ID_MEXT_EN
- Defined: opcode 0110011 with funct7=0000001 decodes as M-extension.
  - MulDiv=1, RegWrite=1, ALUOp=10; funct3 selects MUL..REMU.
  - DIV/DIVU/REM/REMU also set the rd busy bit (multi-cycle result), handled like a load.
- Undefined: funct7=0000001 under 0110011 gives ex_illegal=1 and MulDiv is tied 0.

Test Plan:
1. rst held 2 cycles mid-stream -> ex_valid=0, ex_ctrl=0, in_ready=0; next cycle in_ready=1 and any register reads 0.
2. addi x1,x0,5 (0x00500093) accepted with ex_ready=1 -> next cycle ex_valid=1, ex_rd=1, ex_imm=5, ex_ctrl RegWrite=1, ALUSrc=1.
3. lw x2,0(x1) issued, then add x3,x2,x2 presented -> in_ready=0 until wb_en with wb_rd=2, wb_data=0xDEADBEEF; in that cycle it issues with ex_rs1_val=ex_rs2_val=0xDEADBEEF.
4. ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* stable, in_ready=0; flush then gives ex_valid=0 next cycle.
5. NREGS=16: add x17,x1,x2 -> ex_illegal=1, ex_ctrl=0, no busy bit and no register write.
6. ID_MEXT_EN: div x4,x5,x6 (0x0262C233) -> MulDiv=1, busy[4] set, and a following addi x7,x4,1 stalls until wb_rd=4. With the macro undefined, the same word gives ex_illegal=1.

Source files
------------

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: RV32I (optionally RV32E) decode, register file with write-through bypass,
// load-use/WAW scoreboard and a valid/ready ID/EX register. Define ID_MEXT_EN to decode RV32M.
module id_stage_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [4:0]      ex_rs1,
    output logic [4:0]      ex_rs2,
    output logic [2:0]      ex_funct3,
    output logic [1:0]      ex_aluop,
    output logic [10:0]     ex_ctrl,
    output logic            ex_illegal
);
    localparam int IW = (NREGS == 16) ? 4 : 5;
    localparam logic [5:0] NR = 6'(NREGS);
    localparam logic [NREGS-1:0] ONE = {{(NREGS-1){1'b0}}, 1'b1};

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    // ex_ctrl bit weights, MSB first: RegWrite .. MulDiv
    localparam logic [10:0] C_REGW  = 11'h400;
    localparam logic [10:0] C_ASRC  = 11'h200;
    localparam logic [10:0] C_MRD   = 11'h100;
    localparam logic [10:0] C_MWR   = 11'h080;
    localparam logic [10:0] C_BR    = 11'h040;
    localparam logic [10:0] C_JMP   = 11'h020;
    localparam logic [10:0] C_JR    = 11'h010;
    localparam logic [10:0] C_M2R   = 11'h008;
    localparam logic [10:0] C_AUIPC = 11'h004;
    localparam logic [10:0] C_LUI   = 11'h002;
`ifdef ID_MEXT_EN
    localparam logic [10:0] C_MD    = 11'h001;
`endif

    logic [6:0]         w_opcode, w_funct7;
    logic [10:0]        w_ctrlRaw, w_ctrl;
    logic [1:0]         w_aluopRaw, w_aluop;
    logic               w_usesRs1, w_usesRs2, w_hasRd, w_usesF3, w_knownOp, w_setsBusy;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]    w_imm, w_rs1Val, w_rs2Val;
    logic [4:0]         w_rs1, w_rs2, w_rd;
    logic [2:0]         w_funct3;
    logic               w_rs1Ok, w_rs2Ok, w_rdOk, w_illegal, w_hazard, w_issue, w_wbLegal;
    logic [NREGS-1:0]   w_clr, w_kill, w_set, w_busyEff;

    logic [XLEN-1:0]    r_regs [NREGS];
    logic [NREGS-1:0]   r_busy;
    logic               r_exValid, r_exIllegal, r_exSetsBusy;
    logic [XLEN-1:0]    r_exPc, r_exRs1Val, r_exRs2Val, r_exImm;
    logic [4:0]         r_exRd, r_exRs1, r_exRs2;
    logic [2:0]         r_exFunct3;
    logic [1:0]         r_exAluop;
    logic [10:0]        r_exCtrl;

    assign w_opcode = in_instr[6:0];
    assign w_funct7 = in_instr[31:25];

    always_comb begin
        w_ctrlRaw  = '0;
        w_aluopRaw = 2'b00;
        w_usesRs1  = 1'b0;
        w_usesRs2  = 1'b0;
        w_hasRd    = 1'b0;
        w_usesF3   = 1'b0;
        w_knownOp  = 1'b1;
        w_setsBusy = 1'b0;
        w_imm32    = '0;
        case (w_opcode)
            OP_R: begin
                w_usesRs1  = 1'b1;
                w_usesRs2  = 1'b1;
                w_hasRd    = 1'b1;
                w_usesF3   = 1'b1;
                w_aluopRaw = 2'b10;
                w_ctrlRaw  = C_REGW;
                if (w_funct7 == 7'b0000001) begin
`ifdef ID_MEXT_EN
                    // divide/remainder results arrive late, so they are tracked like loads
                    w_ctrlRaw  = C_REGW | C_MD;
                    w_setsBusy = in_instr[14];
`else
                    w_knownOp  = 1'b0;
`endif
                end
            end
            OP_I: begin
                w_usesRs1 = 1'b1;
                w_hasRd   = 1'b1;
                w_usesF3  = 1'b1;
                w_ctrlRaw = C_REGW | C_ASRC;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LOAD: begin
                w_usesRs1  = 1'b1;
                w_hasRd    = 1'b1;
                w_usesF3   = 1'b1;
                w_setsBusy = 1'b1;
                w_ctrlRaw  = C_REGW | C_ASRC | C_MRD | C_M2R;
                w_imm32    = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_STORE: begin
                w_usesRs1 = 1'b1;
                w_usesRs2 = 1'b1;
                w_usesF3  = 1'b1;
                w_ctrlRaw = C_ASRC | C_MWR;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BR: begin
                w_usesRs1  = 1'b1;
                w_usesRs2  = 1'b1;
                w_usesF3   = 1'b1;
                w_aluopRaw = 2'b01;
                w_ctrlRaw  = C_BR;
                w_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                              in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_JAL: begin
                w_hasRd   = 1'b1;
                w_ctrlRaw = C_REGW | C_JMP;
                w_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_JALR: begin
                w_usesRs1 = 1'b1;
                w_hasRd   = 1'b1;
                w_usesF3  = 1'b1;
                w_ctrlRaw = C_REGW | C_ASRC | C_JR;
                w_imm32   = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_LUI: begin
                w_hasRd   = 1'b1;
                w_ctrlRaw = C_REGW | C_ASRC | C_LUI;
                w_imm32   = {in_instr[31:12], 12'b0};
            end
            OP_AUIPC: begin
                w_hasRd    = 1'b1;
                w_aluopRaw = 2'b11;
                w_ctrlRaw  = C_REGW | C_ASRC | C_AUIPC;
                w_imm32    = {in_instr[31:12], 12'b0};
            end
            default: w_knownOp = 1'b0;
        endcase
    end

    assign w_rs1     = w_usesRs1 ? in_instr[19:15] : 5'd0;
    assign w_rs2     = w_usesRs2 ? in_instr[24:20] : 5'd0;
    assign w_rd      = w_hasRd   ? in_instr[11:7]  : 5'd0;
    assign w_funct3  = w_usesF3  ? in_instr[14:12] : 3'd0;
    assign w_rs1Ok   = {1'b0, w_rs1} < NR;
    assign w_rs2Ok   = {1'b0, w_rs2} < NR;
    assign w_rdOk    = {1'b0, w_rd} < NR;
    assign w_illegal = !w_knownOp || !w_rs1Ok || !w_rs2Ok || !w_rdOk;
    assign w_ctrl    = w_illegal ? 11'd0 : w_ctrlRaw;
    assign w_aluop   = w_illegal ? 2'd0 : w_aluopRaw;
    assign w_imm     = XLEN'(w_imm32);
    assign w_wbLegal = wb_en && ({1'b0, wb_rd} < NR);

    // Indices are truncated to IW bits only once the legality checks above have passed
    always_comb begin
        w_rs1Val = '0;
        w_rs2Val = '0;
        if (w_rs1 != 5'd0 && w_rs1Ok)
            w_rs1Val = (wb_en && wb_rd == w_rs1) ? wb_data : r_regs[IW'(w_rs1)];
        if (w_rs2 != 5'd0 && w_rs2Ok)
            w_rs2Val = (wb_en && wb_rd == w_rs2) ? wb_data : r_regs[IW'(w_rs2)];
    end

    assign w_clr     = w_wbLegal ? (ONE << IW'(wb_rd)) : '0;
    assign w_busyEff = r_busy & ~w_clr;
    assign w_hazard  = !w_illegal &&
                       ((w_usesRs1 && w_busyEff[IW'(w_rs1)]) ||
                        (w_usesRs2 && w_busyEff[IW'(w_rs2)]) ||
                        (w_ctrl[10] && w_rd != 5'd0 && w_busyEff[IW'(w_rd)]));
    assign in_ready  = !rst && !flush && !w_hazard && (!r_exValid || ex_ready);
    assign w_issue   = in_valid && in_ready;
    assign w_set     = (w_issue && w_setsBusy && !w_illegal && w_rd != 5'd0)
                       ? (ONE << IW'(w_rd)) : '0;
    assign w_kill    = (flush && r_exValid && r_exSetsBusy) ? (ONE << IW'(r_exRd)) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (w_wbLegal && wb_rd != 5'd0) begin
            r_regs[IW'(wb_rd)] <= wb_data;
        end
    end

    // A new set beats a same-cycle writeback or flush clear of the same register
    always_ff @(posedge clk) begin
        if (rst) r_busy <= '0;
        else     r_busy <= (r_busy & ~w_clr & ~w_kill) | w_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_exValid    <= 1'b0;
            r_exIllegal  <= 1'b0;
            r_exSetsBusy <= 1'b0;
            r_exPc       <= '0;
            r_exRs1Val   <= '0;
            r_exRs2Val   <= '0;
            r_exImm      <= '0;
            r_exRd       <= '0;
            r_exRs1      <= '0;
            r_exRs2      <= '0;
            r_exFunct3   <= '0;
            r_exAluop    <= '0;
            r_exCtrl     <= '0;
        end else if (flush) begin
            r_exValid <= 1'b0;
        end else if (w_issue) begin
            r_exValid    <= 1'b1;
            r_exIllegal  <= w_illegal;
            r_exSetsBusy <= w_setsBusy && !w_illegal && w_rd != 5'd0;
            r_exPc       <= in_pc;
            r_exRs1Val   <= w_rs1Val;
            r_exRs2Val   <= w_rs2Val;
            r_exImm      <= w_imm;
            r_exRd       <= w_rd;
            r_exRs1      <= w_rs1;
            r_exRs2      <= w_rs2;
            r_exFunct3   <= w_funct3;
            r_exAluop    <= w_aluop;
            r_exCtrl     <= w_ctrl;
        end else if (ex_ready) begin
            r_exValid <= 1'b0;
        end
    end

    assign ex_valid   = r_exValid;
    assign ex_pc      = r_exPc;
    assign ex_rs1_val = r_exRs1Val;
    assign ex_rs2_val = r_exRs2Val;
    assign ex_imm     = r_exImm;
    assign ex_rd      = r_exRd;
    assign ex_rs1     = r_exRs1;
    assign ex_rs2     = r_exRs2;
    assign ex_funct3  = r_exFunct3;
    assign ex_aluop   = r_exAluop;
    assign ex_ctrl    = r_exCtrl;
    assign ex_illegal = r_exIllegal;

endmodule
